// File: rtl/lab1_imul_share_pkg.sv
// Shared types and widths for the multiplier sharing controller.
package lab1_imul_share_pkg;

  localparam int MSG_IN_NBITS  = 64;
  localparam int MSG_OUT_NBITS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/lab1_imul_rr_arb.sv
// Combinational round-robin pick: first asserted request at or after prio,
// wrapping modulo NREQ. The priority pointer itself lives in the caller.
module lab1_imul_rr_arb #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   prio,
  output logic [PW-1:0]   grant,
  output logic            any_req
);

  int unsigned   idx;
  logic [PW-1:0] sel;

  assign any_req = |req;

  // Scan from the farthest slot back to prio so the last hit is the nearest.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    grant = '0;
    idx   = 0;
    sel   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      // NOTE: blocking assignments here; idx/sel are scratch values reused per step.
      idx = 32'(prio) + 32'(k);
      if (idx >= 32'(NREQ)) idx = idx - 32'(NREQ);
      sel = idx[PW-1:0];
      if (req[sel]) grant = sel;
    end
  end

endmodule

// File: rtl/lab1_imul_mul_share_ctrl.sv
// Round-robin sharing of one variable-latency multiplier among NREQ
// requesters; one operation in flight, product returned to its owner only.
module lab1_imul_mul_share_ctrl
  import lab1_imul_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NREQ-1:0]              req_val,
  output logic [NREQ-1:0]              req_rdy,
  input  logic [NREQ*MSG_IN_NBITS-1:0] req_msg,
  output logic [NREQ-1:0]              resp_val,
  input  logic [NREQ-1:0]              resp_rdy,
  output logic [MSG_OUT_NBITS-1:0]     resp_msg,
  output logic                         mul_istream_val,
  input  logic                         mul_istream_rdy,
  output logic [MSG_IN_NBITS-1:0]      mul_istream_msg,
  input  logic                         mul_ostream_val,
  output logic                         mul_ostream_rdy,
  input  logic [MSG_OUT_NBITS-1:0]     mul_ostream_msg
);

  state_t                   state, state_next;
  logic [PW-1:0]            prio, prio_next;
  logic [PW-1:0]            owner, owner_next;
  logic [MSG_OUT_NBITS-1:0] result, result_next;
  logic [PW-1:0]            grant;
  logic                     any_req;

  lab1_imul_rr_arb #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req     (req_val),
    .prio    (prio),
    .grant   (grant),
    .any_req (any_req)
  );

  // State, pointer, owner and buffered product; synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state  <= IDLE;
      prio   <= '0;
      owner  <= '0;
      result <= '0;
    end else begin
      state  <= state_next;
      prio   <= prio_next;
      owner  <= owner_next;
      result <= result_next;
    end
  end

  // Next-state and handshake outputs; all val/rdy held low during reset.
  always_comb begin
    state_next      = state;
    prio_next       = prio;
    owner_next      = owner;
    result_next     = result;
    req_rdy         = '0;
    resp_val        = '0;
    mul_istream_val = 1'b0;
    mul_istream_msg = '0;
    mul_ostream_rdy = 1'b0;
    resp_msg        = result;
    if (!reset) begin
      case (state)
        IDLE: begin
          mul_istream_val = any_req;
          if (any_req) mul_istream_msg = req_msg[int'(grant)*MSG_IN_NBITS +: MSG_IN_NBITS];
          req_rdy[grant] = mul_istream_rdy;
          if (any_req && mul_istream_rdy) begin
            owner_next = grant;
            prio_next  = (grant == PW'(NREQ - 1)) ? '0 : grant + 1'b1;
            state_next = BUSY;
          end
        end
        BUSY: begin
          mul_ostream_rdy = 1'b1;
          if (mul_ostream_val) begin
            result_next = mul_ostream_msg;
            state_next  = RESP;
          end
        end
        RESP: begin
          resp_val[owner] = 1'b1;
          if (resp_rdy[owner]) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule
